cpu_core: RTL and testbench

//  Multi-cycle 16-bit accumulator CPU for the lab's CPU + memory system.

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/cpu_alu.sv | 47 ++++
 rtl/cpu_core.sv | 134 +++++++++++++
 tb/tb_cpu_core.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and field constants for the 16-bit accumulator CPU.
package cpu_pkg;

   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned OPC_MSB    = 15;
   localparam int unsigned OPC_LSB    = 12;
   localparam int unsigned OPD_MSB    = 11;
   localparam int unsigned OPD_LSB    = 0;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_STA = 4'h2,
      OP_ADD = 4'h3,
      OP_SUB = 4'h4,
      OP_AND = 4'h5,
      OP_OR  = 4'h6,
      OP_XOR = 4'h7,
      OP_LDI = 4'h8,
      OP_JMP = 4'h9,
      OP_JZ  = 4'hA,
      OP_JN  = 4'hB,
      OP_JC  = 4'hC,
      OP_SHL = 4'hD,
      OP_SHR = 4'hE,
      OP_HLT = 4'hF
   } opcode_t;

   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXEC    = 3'd2,
      MEMWAIT = 3'd3,
      HALT    = 3'd4
   } state_t;

   // Opcodes whose operand comes from memory and therefore need the MEMWAIT cycle.
   function automatic logic is_mem_read(input opcode_t op);
      logic r;
      r = 1'b0;
      case (op)
         OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: computes the new accumulator and carry for one opcode.
module cpu_alu
   import cpu_pkg::*;
(
   input  opcode_t               op_i,
   input  logic [DATA_WIDTH-1:0] acc_i,
   input  logic [DATA_WIDTH-1:0] opd_i,
   input  logic                  c_i,
   output logic [DATA_WIDTH-1:0] result_c,
   output logic                  c_out_c
);

   logic [DATA_WIDTH:0] wide_c;

   always_comb begin
      result_c = acc_i;
      c_out_c  = c_i;
      wide_c   = '0;
      case (op_i)
         OP_LDA, OP_LDI: result_c = opd_i;
         OP_ADD: begin
            wide_c   = {1'b0, acc_i} + {1'b0, opd_i};
            result_c = wide_c[DATA_WIDTH-1:0];
            c_out_c  = wide_c[DATA_WIDTH];
         end
         // Borrow appears as the bit above the MSB of the zero-extended difference.
         OP_SUB: begin
            wide_c   = {1'b0, acc_i} - {1'b0, opd_i};
            result_c = wide_c[DATA_WIDTH-1:0];
            c_out_c  = wide_c[DATA_WIDTH];
         end
         OP_AND: result_c = acc_i & opd_i;
         OP_OR:  result_c = acc_i | opd_i;
         OP_XOR: result_c = acc_i ^ opd_i;
         OP_SHL: begin
            result_c = {acc_i[DATA_WIDTH-2:0], 1'b0};
            c_out_c  = acc_i[DATA_WIDTH-1];
         end
         OP_SHR: begin
            result_c = {1'b0, acc_i[DATA_WIDTH-1:1]};
            c_out_c  = acc_i[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle accumulator CPU: fetch/decode/execute FSM driving one single-port word memory.
module cpu_core
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_value_i,
   output logic [DATA_WIDTH-1:0] mem_value_o,
   output logic                  mem_enable_o,
   output logic                  mem_wr_en_o,
   output logic                  mem_rd_en_o,
   output logic                  end_program_o
);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] ir_q, ir_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic                  c_q, c_d;

   opcode_t               opc_c;
   logic [ADDR_WIDTH-1:0] opd_addr_c;
   logic [DATA_WIDTH-1:0] alu_opd_c;
   logic [DATA_WIDTH-1:0] alu_res_c;
   logic                  alu_c_c;

   logic [ADDR_WIDTH-1:0] addr_c;
   logic [DATA_WIDTH-1:0] wdata_c;
   logic                  en_c, rd_c, wr_c;

   assign opc_c      = opcode_t'(ir_q[OPC_MSB:OPC_LSB]);
   assign opd_addr_c = ADDR_WIDTH'(ir_q[OPD_MSB:OPD_LSB]);
   // Memory data is the ALU operand only in MEMWAIT; otherwise the zero-extended imm12.
   assign alu_opd_c  = (state_q == MEMWAIT) ? mem_value_i
                                            : DATA_WIDTH'(ir_q[OPD_MSB:OPD_LSB]);

   cpu_alu u_alu (
      .op_i     (opc_c),
      .acc_i    (acc_q),
      .opd_i    (alu_opd_c),
      .c_i      (c_q),
      .result_c (alu_res_c),
      .c_out_c  (alu_c_c)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      c_d     = c_q;
      addr_c  = '0;
      wdata_c = '0;
      en_c    = 1'b0;
      rd_c    = 1'b0;
      wr_c    = 1'b0;
      case (state_q)
         FETCH: begin
            addr_c  = pc_q;
            en_c    = 1'b1;
            rd_c    = 1'b1;
            state_d = DECODE;
         end
         DECODE: begin
            ir_d    = mem_value_i;
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = EXEC;
         end
         EXEC: begin
            state_d = FETCH;
            if (is_mem_read(opc_c)) begin
               addr_c  = opd_addr_c;
               en_c    = 1'b1;
               rd_c    = 1'b1;
               state_d = MEMWAIT;
            end else begin
               case (opc_c)
                  OP_STA: begin
                     addr_c  = opd_addr_c;
                     en_c    = 1'b1;
                     wr_c    = 1'b1;
                     wdata_c = acc_q;
                  end
                  OP_LDI, OP_SHL, OP_SHR: begin
                     acc_d = alu_res_c;
                     c_d   = alu_c_c;
                  end
                  OP_JMP: pc_d = opd_addr_c;
                  OP_JZ:  if (acc_q == '0)           pc_d = opd_addr_c;
                  OP_JN:  if (acc_q[DATA_WIDTH-1])   pc_d = opd_addr_c;
                  OP_JC:  if (c_q)                   pc_d = opd_addr_c;
                  OP_HLT: state_d = HALT;
                  default: ;
               endcase
            end
         end
         MEMWAIT: begin
            acc_d   = alu_res_c;
            c_d     = alu_c_c;
            state_d = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   // Bus is forced idle while reset is asserted, so nothing leaks out of the FETCH reset state.
   assign mem_addr_o    = rst_i ? addr_c  : '0;
   assign mem_value_o   = rst_i ? wdata_c : '0;
   assign mem_enable_o  = rst_i & en_c;
   assign mem_rd_en_o   = rst_i & rd_c;
   assign mem_wr_en_o   = rst_i & wr_c;
   assign end_program_o = rst_i & (state_q == HALT);

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: behavioural memory, ISA-level reference model, vectors and random programs.
module tb_cpu_core;
   import cpu_pkg::*;

   localparam int unsigned AW   = 12;
   localparam int          MAXC = 3000;

   logic          clk_i;
   logic          rst_i;
   logic [AW-1:0] mem_addr_o;
   logic [15:0]   mem_value_i;
   logic [15:0]   mem_value_o;
   logic          mem_enable_o, mem_wr_en_o, mem_rd_en_o, end_program_o;

   cpu_core #(.ADDR_WIDTH(AW)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .mem_addr_o    (mem_addr_o),
      .mem_value_i   (mem_value_i),
      .mem_value_o   (mem_value_o),
      .mem_enable_o  (mem_enable_o),
      .mem_wr_en_o   (mem_wr_en_o),
      .mem_rd_en_o   (mem_rd_en_o),
      .end_program_o (end_program_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [11:0] a;
      logic [15:0] d;
   } wr_t;

   logic [15:0] mem   [4096];
   logic [15:0] img   [4096];
   logic [15:0] ref_m [4096];
   logic [15:0] mem_dout;
   wr_t         wr_log[$];
   wr_t         exp_log[$];
   int          mon_bad;
   int          errors;
   int          checks;

   assign mem_value_i = mem_dout;

   // Single-port synchronous RAM; write wins over read and dout then holds.
   always @(posedge clk_i) begin
      if (mem_enable_o) begin
         if (mem_wr_en_o) begin
            mem[mem_addr_o] <= mem_value_o;
            wr_log.push_back({mem_addr_o, mem_value_o});
         end else if (mem_rd_en_o) begin
            mem_dout <= mem[mem_addr_o];
         end
      end
   end

   // Bus-protocol watchdog over the whole run.
   always @(negedge clk_i) begin
      #1;
      if (mem_rd_en_o && mem_wr_en_o) mon_bad <= mon_bad + 1;
      if ((mem_rd_en_o || mem_wr_en_o) && !mem_enable_o) mon_bad <= mon_bad + 1;
      if (end_program_o && mem_enable_o) mon_bad <= mon_bad + 1;
      if (!rst_i && (mem_enable_o || mem_rd_en_o || mem_wr_en_o || end_program_o
                     || mem_addr_o != '0 || mem_value_o != '0)) mon_bad <= mon_bad + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) begin
         mem[i] <= 16'h0000;
         img[i] = 16'h0000;
      end
   endtask

   task automatic poke(input logic [11:0] a, input logic [15:0] d);
      mem[a] <= d;
      img[a] = d;
   endtask

   function automatic logic [15:0] ins(input logic [3:0] op, input logic [11:0] a);
      return {op, a};
   endfunction

   task automatic hold_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   // Releases reset and counts rising edges until end_program_o is seen.
   task automatic run_dut(input string name, output int cyc);
      wr_log.delete();
      rst_i = 1'b1;
      cyc = 0;
      #1;
      while (!end_program_o && cyc < MAXC) begin
         @(posedge clk_i);
         cyc++;
         @(negedge clk_i);
      end
      if (!end_program_o) chk({name, "_timeout"}, 32'(cyc), 32'(MAXC + 1));
   endtask

   // Instruction-level interpreter: whole instructions at a time, with per-instruction cycle cost.
   task automatic model_run(output int cyc);
      logic [11:0] pc;
      logic [15:0] acc, ir, m;
      bit          c, done;
      int          t;
      for (int i = 0; i < 4096; i++) ref_m[i] = img[i];
      exp_log.delete();
      pc = 0; acc = 0; c = 0; cyc = 0; done = 0;
      for (int n = 0; n < 20000 && !done; n++) begin
         ir = ref_m[pc];
         pc = pc + 12'd1;
         m  = ref_m[ir[11:0]];
         cyc += 3;
         case (ir[15:12])
            4'h1: begin acc = m; cyc += 1; end
            4'h2: begin ref_m[ir[11:0]] = acc; exp_log.push_back({ir[11:0], acc}); end
            4'h3: begin t = int'(acc) + int'(m); c = (t > 65535); acc = 16'(t); cyc += 1; end
            4'h4: begin c = (acc < m); acc = acc - m; cyc += 1; end
            4'h5: begin acc = acc & m; cyc += 1; end
            4'h6: begin acc = acc | m; cyc += 1; end
            4'h7: begin acc = acc ^ m; cyc += 1; end
            4'h8: acc = 16'(ir[11:0]);
            4'h9: pc = ir[11:0];
            4'hA: if (acc == 16'd0) pc = ir[11:0];
            4'hB: if (acc >= 16'h8000) pc = ir[11:0];
            4'hC: if (c) pc = ir[11:0];
            4'hD: begin c = (acc >= 16'h8000); acc = 16'(int'(acc) * 2); end
            4'hE: begin c = (acc % 2) == 1; acc = acc / 2; end
            4'hF: done = 1;
            default: ;
         endcase
      end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a_init;
      logic [15:0] opd;
      logic [15:0] exp_acc;
      logic        exp_c;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int cyc, mcyc;
      logic [15:0] w;
      rst_i = 1'b0;
      errors = 0; checks = 0; mon_bad = 0;
      clear_mem();

      vecs.push_back('{4'h3, 16'h0123, 16'hFFFF, 16'h0122, 1'b1});
      vecs.push_back('{4'h4, 16'h8000, 16'h0001, 16'h7FFF, 1'b0});
      vecs.push_back('{4'h4, 16'h0001, 16'h0002, 16'hFFFF, 1'b1});
      vecs.push_back('{4'h5, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0});
      vecs.push_back('{4'h6, 16'hF0F0, 16'h0F01, 16'hFFF1, 1'b0});
      vecs.push_back('{4'h7, 16'hFFFF, 16'h1234, 16'hEDCB, 1'b0});
      vecs.push_back('{4'hD, 16'h8001, 16'h0000, 16'h0002, 1'b1});
      vecs.push_back('{4'hE, 16'h8001, 16'h0000, 16'h4000, 1'b1});
      vecs.push_back('{4'hE, 16'h0002, 16'h0000, 16'h0001, 1'b0});
      vecs.push_back('{4'h1, 16'h1111, 16'hBEEF, 16'hBEEF, 1'b0});
      vecs.push_back('{4'h8, 16'hFFFF, 16'h0000, 16'h0101, 1'b0});
      vecs.push_back('{4'h0, 16'h5A5A, 16'h0000, 16'h5A5A, 1'b0});

      // Reset held for three cycles: bus idle, then fetch of address 0 right after release.
      repeat (3) begin
         @(negedge clk_i); #1;
         chk("rst_enable", 32'(mem_enable_o), 32'd0);
         chk("rst_strobes", 32'({mem_rd_en_o, mem_wr_en_o, end_program_o}), 32'd0);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      chk("first_fetch", 32'({mem_enable_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o}), 32'({3'b110, 12'h000}));

      // Spec example program LDI/ADD/STA/HLT.
      hold_reset();
      clear_mem();
      poke(12'h000, ins(4'h8, 12'h123));
      poke(12'h001, ins(4'h3, 12'h100));
      poke(12'h002, ins(4'h2, 12'h101));
      poke(12'h003, ins(4'hF, 12'h000));
      poke(12'h100, 16'hFFFF);
      run_dut("ex1", cyc);
      chk("ex1_store", 32'(mem[12'h101]), 32'h0122);
      chk("ex1_cycles", 32'(cyc), 32'd13);
      repeat (4) @(negedge clk_i);
      chk("ex1_halt_sticky", 32'(end_program_o), 32'd1);

      // Table of single-op vectors; C is exposed via JC into M[0x103].
      foreach (vecs[k]) begin
         hold_reset();
         clear_mem();
         poke(12'h000, ins(4'h1, 12'h100));
         poke(12'h001, ins(vecs[k].op, 12'h101));
         poke(12'h002, ins(4'h2, 12'h102));
         poke(12'h003, ins(4'hC, 12'h006));
         poke(12'h004, ins(4'h8, 12'h000));
         poke(12'h005, ins(4'h9, 12'h007));
         poke(12'h006, ins(4'h8, 12'h001));
         poke(12'h007, ins(4'h2, 12'h103));
         poke(12'h008, ins(4'hF, 12'h000));
         poke(12'h100, vecs[k].a_init);
         poke(12'h101, vecs[k].opd);
         model_run(mcyc);
         run_dut($sformatf("vec%0d", k), cyc);
         chk($sformatf("vec%0d_acc", k), 32'(mem[12'h102]), 32'(vecs[k].exp_acc));
         chk($sformatf("vec%0d_c", k), 32'(mem[12'h103]), 32'(vecs[k].exp_c));
         chk($sformatf("vec%0d_cycles", k), 32'(cyc), 32'(mcyc));
      end

      // SUB to 0x7FFF: JN and JZ both fall through.
      hold_reset();
      clear_mem();
      poke(12'h000, ins(4'h1, 12'h100));
      poke(12'h001, ins(4'h4, 12'h101));
      poke(12'h002, ins(4'hB, 12'h300));
      poke(12'h003, ins(4'hA, 12'h300));
      poke(12'h004, ins(4'h2, 12'h102));
      poke(12'h005, ins(4'hF, 12'h000));
      poke(12'h100, 16'h8000);
      poke(12'h101, 16'h0001);
      poke(12'h300, ins(4'h8, 12'hBAD));
      poke(12'h301, ins(4'h2, 12'h102));
      poke(12'h302, ins(4'hF, 12'h000));
      run_dut("jnjz", cyc);
      chk("jnjz_not_taken", 32'(mem[12'h102]), 32'h7FFF);

      // ACC=0: JZ taken to 0x200, then JC with C=0 falls through.
      hold_reset();
      clear_mem();
      poke(12'h000, ins(4'h8, 12'h000));
      poke(12'h001, ins(4'hA, 12'h200));
      poke(12'h002, ins(4'h8, 12'h666));
      poke(12'h003, ins(4'h2, 12'h101));
      poke(12'h004, ins(4'hF, 12'h000));
      poke(12'h200, ins(4'hC, 12'h300));
      poke(12'h201, ins(4'h8, 12'h777));
      poke(12'h202, ins(4'h2, 12'h101));
      poke(12'h203, ins(4'hF, 12'h000));
      poke(12'h300, ins(4'h8, 12'h999));
      poke(12'h301, ins(4'h2, 12'h101));
      poke(12'h302, ins(4'hF, 12'h000));
      run_dut("jzjc", cyc);
      chk("jzjc_path", 32'(mem[12'h101]), 32'h0777);

      // JMP 0xFFF then NOP: PC wraps and the next fetch is address 0.
      hold_reset();
      clear_mem();
      poke(12'h000, ins(4'h9, 12'hFFF));
      poke(12'hFFF, ins(4'h0, 12'h000));
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("wrap_fetch_fff", 32'({mem_rd_en_o, mem_addr_o}), 32'({1'b1, 12'hFFF}));
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("wrap_fetch_000", 32'({mem_rd_en_o, mem_addr_o}), 32'({1'b1, 12'h000}));

      // Reset asserted during STA EXEC: write dropped, restart from 0.
      hold_reset();
      clear_mem();
      poke(12'h000, ins(4'h8, 12'h055));
      poke(12'h001, ins(4'h2, 12'h101));
      poke(12'h002, ins(4'hF, 12'h000));
      poke(12'h101, 16'h1111);
      wr_log.delete();
      rst_i = 1'b1;
      repeat (5) @(posedge clk_i);
      @(negedge clk_i);
      chk("sta_exec_bus", 32'({mem_wr_en_o, mem_rd_en_o, mem_addr_o, mem_value_o}),
          32'({1'b1, 1'b0, 12'h101, 16'h0055}));
      #2 rst_i = 1'b0;
      #1;
      chk("sta_rst_idle", 32'({mem_enable_o, mem_wr_en_o, mem_rd_en_o}), 32'd0);
      repeat (3) @(negedge clk_i);
      chk("sta_rst_mem", 32'(mem[12'h101]), 32'h1111);
      chk("sta_rst_nowrite", 32'(wr_log.size()), 32'd0);
      rst_i = 1'b1;
      #1;
      chk("sta_rst_refetch", 32'({mem_enable_o, mem_rd_en_o, mem_addr_o}), 32'({2'b11, 12'h000}));

      // Random forward-branching programs against the reference interpreter.
      for (int p = 0; p < 25; p++) begin
         hold_reset();
         clear_mem();
         for (int i = 0; i < 30; i++) begin
            logic [3:0]  op;
            logic [11:0] a;
            op = 4'($urandom_range(0, 14));
            if (op >= 4'h9 && op <= 4'hC) a = 12'($urandom_range(i + 1, 30));
            else if (op == 4'h8)           a = 12'($urandom);
            else                           a = 12'h100 + 12'($urandom_range(0, 7));
            poke(12'(i), ins(op, a));
         end
         poke(12'd30, ins(4'hF, 12'h000));
         for (int j = 0; j < 8; j++) begin
            w = 16'($urandom);
            poke(12'h100 + 12'(j), w);
         end
         model_run(mcyc);
         run_dut($sformatf("rnd%0d", p), cyc);
         chk($sformatf("rnd%0d_cycles", p), 32'(cyc), 32'(mcyc));
         chk($sformatf("rnd%0d_nwr", p), 32'(wr_log.size()), 32'(exp_log.size()));
         foreach (exp_log[k]) begin
            if (k < wr_log.size())
               chk($sformatf("rnd%0d_wr%0d", p, k), 32'(wr_log[k]), 32'(exp_log[k]));
         end
         for (int j = 0; j < 8; j++)
            chk($sformatf("rnd%0d_m%0d", p, j), 32'(mem[12'h100 + 12'(j)]), 32'(ref_m[12'h100 + 12'(j)]));
      end

      repeat (2) @(negedge clk_i);
      chk("bus_protocol", 32'(mon_bad), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
